dpi_stream_sequencer: RTL and testbench
=======================================

# dpi_stream_sequencer

Front-end controller for the regex-matcher bank of the DPI core. Accepts byte-serial packets tagged with a flow key and maps each key to a 6-bit stream slot, allocating a slot or evicting one when needed. It then sequences the shared `load_state`, `char_in`/`char_in_vld`, `eop`, `stream_id`, `new_stream_id` and per-regex `enable` bus that drives every `cancid_*` matcher wrapper. It guarantees the wrappers' save/restore pipeline timing, so matchers never see a char before their restored state or an `eop` before their last accept has landed.

## Interface
Parameters:
- `KEY_W`, 16: flow-key width.
- `NUM_REGEX`, 8: number of matcher wrappers driven; width of `enable`.
- `DRAIN_CYCLES`, 4: idle cycles between the last char and `eop`. Must be ≥ 3 to cover the wrapper register stages.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `pkt_vld`, in, 1: packet beat valid.
- `pkt_rdy`, out, 1: beat accepted when `pkt_vld & pkt_rdy`.
- `pkt_sop`, in, 1: first beat of packet.
- `pkt_eop`, in, 1: last beat of packet.
- `pkt_data`, in, 8: one byte per beat.
- `pkt_key`, in, KEY_W: flow key, sampled only on a sop beat.
- `cfg_we`, in, 1: write the per-stream enable table.
- `cfg_stream`, in, 6: table index.
- `cfg_enable`, in, NUM_REGEX: enable bits for the indexed stream.
- `char_in`, out, 8: to all wrappers.
- `char_in_vld`, out, 1: to all wrappers.
- `load_state`, out, 1: one-cycle restore pulse.
- `eop`, out, 1: one-cycle finalize pulse.
- `stream_id`, out, 6: current slot.
- `new_stream_id`, out, 1: slot is fresh, so matchers reset state.
- `enable`, out, NUM_REGEX: per-wrapper enable for the current stream.
- `busy`, out, 1: FSM not in IDLE.
- `pkt_count`, out, 32: packets completed.
- `evict_count`, out, 16: slot evictions.
- `err_sticky`, out, 1: protocol error seen.

## Operation
- **Stream table:** 64 entries of {valid, key}, plus a 64×NUM_REGEX enable table. On reset, all valid bits clear and all enable bits are set.
- **FSM states:** IDLE → LOOKUP → LOAD → GAP → STREAM → DRAIN → EOP → IDLE.
- **IDLE:** `pkt_rdy=0`.
  - On `pkt_vld & pkt_sop`, latch `pkt_key` without consuming the beat, then go to LOOKUP.
  - On `pkt_vld & ~pkt_sop`, set `pkt_rdy=1` for that cycle, discard the beat and set `err_sticky`.
- **LOOKUP:** one cycle, parallel compare against all valid keys.
  - Hit: slot = matching index (lowest index on duplicate hits), `new_stream_id=0`.
  - Miss with a free slot: slot = lowest invalid index, `new_stream_id=1`.
  - Miss with the table full: slot = round-robin victim pointer, `new_stream_id=1`, victim pointer increments mod 64, `evict_count` increments (saturating).
  - On a miss, write the key and set valid.
  - `stream_id`, `new_stream_id` and `enable` are registered here and held constant through EOP.
- **LOAD:** `load_state=1` for exactly one cycle.
- **GAP:** one idle cycle; wrapper state restore reaches the DFA input stage.
- **STREAM:** `pkt_rdy=1`. Each accepted beat drives `char_in=pkt_data` and `char_in_vld=1` in the same cycle; `char_in_vld=0` on bubbles.
  - A sop beat inside STREAM is accepted as data and sets `err_sticky`.
  - The accepted beat with `pkt_eop=1` moves the FSM to DRAIN.
- **DRAIN:** `pkt_rdy=0`, `char_in_vld=0`; counter runs DRAIN_CYCLES cycles.
- **EOP:** `eop=1` for one cycle; `pkt_count` increments (wrapping); next state is IDLE.
- **Config writes:** apply in any state, with effect from the next LOOKUP. A write to the current slot does not change the `enable` output already latched.

## Timing
- Reset values: all outputs 0 except `enable`, which is 0 until the first LOOKUP; FSM in IDLE; counters 0.
- For a packet of L beats presented back-to-back with sop at cycle T:
  - `load_state` at T+2.
  - First `char_in_vld` at T+4.
  - Last char at T+3+L.
  - `eop` at T+4+L+DRAIN_CYCLES.
  - Next sop is sampled at T+5+L+DRAIN_CYCLES at the earliest.
- The minimum gap from `load_state` to the first char is 2 cycles; the minimum gap from the last char to `eop` is DRAIN_CYCLES+1.
- `load_state`, `char_in_vld` and `eop` are mutually exclusive in every cycle.
- A reset assertion mid-packet returns the FSM to IDLE next cycle, clears the table, and drops the packet without `eop`.

## Structure
- Shared package `dpi_pkg`: FSM state enum, `STREAM_ID_W=6`, `NUM_STREAMS=64`, default `DRAIN_CYCLES`.
- One sub-module, `dpi_stream_table`: key CAM with valid bits, lowest-free priority encoder, victim pointer, and the enable RAM. It returns {hit, slot, new, enable} one cycle after a lookup strobe.

## Test plan
- **New flow:** key 0x1234, 5-byte packet "ABCDE" → `stream_id=0`, `new_stream_id=1`, `load_state` at T+2, chars at T+4..T+8, `eop` at T+13, `pkt_count=1`.
- **Repeat flow:** second packet with key 0x1234 after 0x5555 → `stream_id=0`, `new_stream_id=0`; 0x5555 took slot 1.
- **Backpressure:** `pkt_vld` gaps inside a packet → `char_in_vld` low on the same cycles; `eop` is still DRAIN_CYCLES+1 after the last char.
- **Eviction:** 65 distinct keys → the 65th gets `stream_id=0`, `new_stream_id=1`, `evict_count=1`; the 66th distinct key gets slot 1.
- **Config:** `cfg_we` with stream 3 and mask 0x05 before key→slot 3 → `enable=0x05` held LOAD..EOP; a mid-packet write to slot 3 does not change `enable`.
- **Errors/reset:** a non-sop beat in IDLE is consumed and sets `err_sticky`; `rst_n=0` during STREAM → no `eop`, outputs 0, and the next packet's key gets `new_stream_id=1`.

Source files
------------

// File: rtl/dpi_pkg.sv
// dpi_pkg: shared types and sizes for the DPI stream sequencer
package dpi_pkg;
    localparam int STREAM_ID_W      = 6;
    localparam int NUM_STREAMS      = 64;
    localparam int DEF_DRAIN_CYCLES = 4;
    typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP} state_t;
endpackage

// File: rtl/dpi_stream_sequencer_if.sv
// dpi_stream_sequencer_if: byte-serial packet stream with flow key
interface dpi_stream_sequencer_if #(parameter int KEY_W = 16);
    logic             pkt_vld;
    logic             pkt_rdy;
    logic             pkt_sop;
    logic             pkt_eop;
    logic [7:0]       pkt_data;
    logic [KEY_W-1:0] pkt_key;
    modport master (output pkt_vld, pkt_sop, pkt_eop, pkt_data, pkt_key, input pkt_rdy);
    modport slave  (input pkt_vld, pkt_sop, pkt_eop, pkt_data, pkt_key, output pkt_rdy);
endinterface

// File: rtl/dpi_stream_table.sv
// dpi_stream_table: key CAM, slot allocation/eviction and per-stream enable RAM
module dpi_stream_table
    import dpi_pkg::*;
#(
    parameter int KEY_W     = 16,
    parameter int NUM_REGEX = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lookup,
    input  logic [KEY_W-1:0]       key,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_stream,
    input  logic [NUM_REGEX-1:0]   cfg_enable,
    output logic [STREAM_ID_W-1:0] slot,
    output logic                   fresh,
    output logic [NUM_REGEX-1:0]   enable,
    output logic                   evict
);
    logic [NUM_STREAMS-1:0] valid;
    logic [KEY_W-1:0]       keys   [NUM_STREAMS];
    logic [NUM_REGEX-1:0]   en_ram [NUM_STREAMS];
    logic [STREAM_ID_W-1:0] victim, hit_idx, free_idx, pick;
    logic                   hit_c, free_c;

    // Priority encoders: lowest matching slot and lowest free slot
    always_comb begin
        hit_c    = 1'b0;
        free_c   = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (valid[i] && keys[i] == key) begin
                hit_c   = 1'b1;
                hit_idx = i[STREAM_ID_W-1:0];
            end
            if (!valid[i]) begin
                free_c   = 1'b1;
                free_idx = i[STREAM_ID_W-1:0];
            end
        end
        pick  = hit_c ? hit_idx : (free_c ? free_idx : victim);
        evict = lookup && !hit_c && !free_c;
    end

    // Table update and registered lookup result; enable read sees pre-write contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= '0;
            victim <= '0;
            slot   <= '0;
            fresh  <= 1'b0;
            enable <= '0;
            en_ram <= '{default: '1};
        end else begin
            if (cfg_we) en_ram[cfg_stream] <= cfg_enable;
            if (lookup) begin
                slot   <= pick;
                fresh  <= !hit_c;
                enable <= en_ram[pick];
                if (!hit_c) begin
                    valid[pick] <= 1'b1;
                    keys[pick]  <= key;
                end
                if (evict) victim <= victim + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: maps flow keys to slots and sequences the shared matcher bus
module dpi_stream_sequencer
    import dpi_pkg::*;
#(
    parameter int KEY_W        = 16,
    parameter int NUM_REGEX    = 8,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dpi_stream_sequencer_if.slave  pkt,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_stream,
    input  logic [NUM_REGEX-1:0]   cfg_enable,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   load_state,
    output logic                   eop,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   new_stream_id,
    output logic [NUM_REGEX-1:0]   enable,
    output logic                   busy,
    output logic [31:0]            pkt_count,
    output logic [15:0]            evict_count,
    output logic                   err_sticky
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    state_t           state, nxt;
    logic [KEY_W-1:0] key_q;
    logic [CW-1:0]    cnt;
    logic             rdy, acc, first, evict;

    dpi_stream_table #(.KEY_W(KEY_W), .NUM_REGEX(NUM_REGEX)) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup     (state == LOOKUP),
        .key        (key_q),
        .cfg_we     (cfg_we),
        .cfg_stream (cfg_stream),
        .cfg_enable (cfg_enable),
        .slot       (stream_id),
        .fresh      (new_stream_id),
        .enable     (enable),
        .evict      (evict)
    );

    assign pkt.pkt_rdy = rdy;
    assign acc         = pkt.pkt_vld && rdy;
    assign busy        = state != IDLE;
    assign char_in     = char_in_vld ? pkt.pkt_data : 8'h00;

    // Next state and bus strobes; IDLE swallows stray non-sop beats
    always_comb begin
        nxt         = state;
        rdy         = 1'b0;
        char_in_vld = 1'b0;
        load_state  = 1'b0;
        eop         = 1'b0;
        case (state)
            IDLE: begin
                rdy = pkt.pkt_vld && !pkt.pkt_sop;
                nxt = (pkt.pkt_vld && pkt.pkt_sop) ? LOOKUP : IDLE;
            end
            LOOKUP: nxt = LOAD;
            LOAD: begin
                load_state = 1'b1;
                nxt        = GAP;
            end
            GAP: nxt = STREAM;
            STREAM: begin
                rdy         = 1'b1;
                char_in_vld = pkt.pkt_vld;
                nxt         = (pkt.pkt_vld && pkt.pkt_eop) ? DRAIN : STREAM;
            end
            DRAIN: nxt = (cnt == CW'(DRAIN_CYCLES - 1)) ? EOP : DRAIN;
            EOP: begin
                eop = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State, key latch, drain counter, statistics and sticky protocol error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_q       <= '0;
            cnt         <= '0;
            first       <= 1'b0;
            pkt_count   <= '0;
            evict_count <= '0;
            err_sticky  <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && pkt.pkt_vld && pkt.pkt_sop) key_q <= pkt.pkt_key;
            cnt   <= (state == DRAIN) ? cnt + 1'b1 : '0;
            first <= (state == GAP) ? 1'b1 : (acc ? 1'b0 : first);
            if (state == EOP) pkt_count <= pkt_count + 1'b1;
            if (evict && evict_count != 16'hFFFF) evict_count <= evict_count + 1'b1;
            if (acc && (state == IDLE || (pkt.pkt_sop && !first))) err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: directed+random checks against a slot-table reference model
module tb_dpi_stream_sequencer;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpi_stream_sequencer_if #(.KEY_W(16)) pif ();

    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_stream = '0;
    logic [7:0]  cfg_enable = '0;
    logic [7:0]  char_in, enable;
    logic        char_in_vld, load_state, eop, new_stream_id, busy, err_sticky;
    logic [5:0]  stream_id;
    logic [31:0] pkt_count;
    logic [15:0] evict_count;

    dpi_stream_sequencer #(.KEY_W(16), .NUM_REGEX(8), .DRAIN_CYCLES(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt           (pif),
        .cfg_we        (cfg_we),
        .cfg_stream    (cfg_stream),
        .cfg_enable    (cfg_enable),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .load_state    (load_state),
        .eop           (eop),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .enable        (enable),
        .busy          (busy),
        .pkt_count     (pkt_count),
        .evict_count   (evict_count),
        .err_sticky    (err_sticky)
    );

    int total = 0;
    int bad = 0;

    bit          mv   [64];
    logic [15:0] mk   [64];
    logic [7:0]  en_m [64];
    int          victim, evicts, pcount;
    bit          err_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[s]   = 1'b0;
            en_m[s] = 8'hFF;
        end
        victim = 0;
        evicts = 0;
        pcount = 0;
        err_m  = 1'b0;
    endtask

    task automatic model_lookup(input logic [15:0] key, output int slot, output bit fresh);
        slot = -1;
        for (int s = 0; s < 64; s++)
            if (slot < 0 && mv[s] && mk[s] == key) slot = s;
        fresh = slot < 0;
        if (fresh) begin
            for (int s = 0; s < 64; s++)
                if (slot < 0 && !mv[s]) slot = s;
            if (slot < 0) begin
                slot   = victim;
                victim = (victim + 1) % 64;
                evicts++;
            end
            mv[slot] = 1'b1;
            mk[slot] = key;
        end
    endtask

    task automatic send_pkt(input logic [15:0] key, input int len, input int gap_pct, input bit mid_cfg);
        logic [7:0] d [$];
        logic [7:0] en;
        int slot, i;
        bit fresh;
        model_lookup(key, slot, fresh);
        en = en_m[slot];
        for (int k = 0; k < len; k++) d.push_back(8'($urandom));
        cyc();
        pif.pkt_vld = 1'b1; pif.pkt_sop = 1'b1; pif.pkt_eop = (len == 1);
        pif.pkt_data = d[0]; pif.pkt_key = key;
        #1;
        chk("idle_rdy", 32'(pif.pkt_rdy), 0);
        chk("idle_busy", 32'(busy), 0);
        cyc(); #1;
        chk("lookup_busy", 32'(busy), 1);
        chk("lookup_load", 32'(load_state), 0);
        cyc(); #1;
        chk("load_pulse", 32'(load_state), 1);
        chk("stream_id", 32'(stream_id), 32'(slot));
        chk("new_stream_id", 32'(new_stream_id), 32'(fresh));
        chk("enable", 32'(enable), 32'(en));
        cyc(); #1;
        chk("gap_vld", 32'(char_in_vld), 0);
        chk("gap_load", 32'(load_state), 0);
        i = 0;
        while (i < len) begin
            cyc();
            cfg_we = 1'b0;
            if (i > 0 && $urandom_range(99) < gap_pct) begin
                pif.pkt_vld = 1'b0;
                #1;
                chk("bubble_vld", 32'(char_in_vld), 0);
            end else begin
                pif.pkt_vld = 1'b1; pif.pkt_sop = (i == 0); pif.pkt_eop = (i == len - 1);
                pif.pkt_data = d[i];
                if (mid_cfg && i == 1) begin
                    cfg_we = 1'b1; cfg_stream = 6'(slot); cfg_enable = ~en;
                    en_m[slot] = ~en;
                end
                #1;
                chk("char_vld", 32'(char_in_vld), 1);
                chk("char_in", 32'(char_in), 32'(d[i]));
                chk("stream_rdy", 32'(pif.pkt_rdy), 1);
                chk("stream_en_held", 32'(enable), 32'(en));
                i++;
            end
        end
        for (int k = 0; k < D; k++) begin
            cyc();
            pif.pkt_vld = 1'b0; pif.pkt_sop = 1'b0; pif.pkt_eop = 1'b0; cfg_we = 1'b0;
            #1;
            chk("drain_eop", 32'(eop), 0);
            chk("drain_vld", 32'(char_in_vld), 0);
            chk("drain_rdy", 32'(pif.pkt_rdy), 0);
        end
        cyc(); #1;
        chk("eop_pulse", 32'(eop), 1);
        chk("eop_sid", 32'(stream_id), 32'(slot));
        chk("eop_en", 32'(enable), 32'(en));
        pcount++;
        cyc(); #1;
        chk("after_eop", 32'(eop), 0);
        chk("after_busy", 32'(busy), 0);
        chk("pkt_count", pkt_count, 32'(pcount));
        chk("evict_count", 32'(evict_count), 32'(evicts));
        chk("err_sticky", 32'(err_sticky), 32'(err_m));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            assert (32'(load_state) + 32'(char_in_vld) + 32'(eop) <= 1) else begin
                bad++;
                $error("FAIL excl: load=%0b vld=%0b eop=%0b expected at most one", load_state, char_in_vld, eop);
            end
        end
    end

    initial begin
        pif.pkt_vld = 1'b0; pif.pkt_sop = 1'b0; pif.pkt_eop = 1'b0;
        pif.pkt_data = '0; pif.pkt_key = '0;
        model_reset();
        repeat (3) cyc();
        chk("rst_char_vld", 32'(char_in_vld), 0);
        chk("rst_load", 32'(load_state), 0);
        chk("rst_eop", 32'(eop), 0);
        chk("rst_sid", 32'(stream_id), 0);
        chk("rst_new", 32'(new_stream_id), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_evict", 32'(evict_count), 0);
        chk("rst_err", 32'(err_sticky), 0);
        rst_n = 1'b1;

        send_pkt(16'h1234, 5, 0, 1'b0);
        send_pkt(16'h5555, 3, 0, 1'b0);
        send_pkt(16'h1234, 4, 0, 1'b0);
        send_pkt(16'h7777, 8, 40, 1'b0);

        cyc();
        cfg_we = 1'b1; cfg_stream = 6'd3; cfg_enable = 8'h05; en_m[3] = 8'h05;
        cyc();
        cfg_we = 1'b0;
        send_pkt(16'h0333, 6, 25, 1'b1);
        send_pkt(16'h0333, 3, 0, 1'b0);

        cyc();
        pif.pkt_vld = 1'b1; pif.pkt_sop = 1'b0; pif.pkt_data = 8'h5A;
        #1;
        chk("stray_rdy", 32'(pif.pkt_rdy), 1);
        cyc();
        pif.pkt_vld = 1'b0;
        #1;
        chk("stray_err", 32'(err_sticky), 1);
        chk("stray_busy", 32'(busy), 0);
        err_m = 1'b1;
        send_pkt(16'h4242, 2, 0, 1'b0);

        cyc();
        pif.pkt_vld = 1'b1; pif.pkt_sop = 1'b1; pif.pkt_eop = 1'b0;
        pif.pkt_key = 16'hABCD; pif.pkt_data = 8'h11;
        repeat (4) cyc();
        chk("pre_rst_vld", 32'(char_in_vld), 1);
        cyc();
        rst_n = 1'b0; pif.pkt_vld = 1'b0;
        cyc();
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_enable", 32'(enable), 0);
        chk("mid_rst_sid", 32'(stream_id), 0);
        chk("mid_rst_count", pkt_count, 0);
        chk("mid_rst_err", 32'(err_sticky), 0);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < D + 4; k++) begin
            cyc();
            chk("mid_rst_no_eop", 32'(eop), 0);
        end

        send_pkt(16'h1234, 3, 0, 1'b0);
        for (int k = 0; k < 63; k++)
            send_pkt(16'h8000 + 16'(k), $urandom_range(1, 4), 20, 1'b0);
        send_pkt(16'h9000, 2, 0, 1'b0);
        send_pkt(16'h9001, 2, 0, 1'b0);
        chk("final_evicts", 32'(evict_count), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
